// File: rtl/fp_edge_pkg.sv
// Shared definitions for the binary32 edge-operand stimulus driver: operand table,
// flag positions, rounding-mode encodings, FSM states and float classification helpers.
package fp_edge_pkg;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0] RM_RNE = 5'b00001;
    localparam logic [4:0] RM_RNA = 5'b00010;
    localparam logic [4:0] RM_RTP = 5'b00100;
    localparam logic [4:0] RM_RTN = 5'b01000;
    localparam logic [4:0] RM_RTZ = 5'b10000;

    localparam logic [2:0] RM_IDX_LAST = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    // rm_idx is the fastest-changing field; c_code is the most significant.
    typedef struct packed {
        logic [3:0] c_code;
        logic [3:0] a_code;
        logic [3:0] b_code;
        logic [2:0] rm_idx;
    } vec_idx_t;

    function automatic logic [31:0] mag_table(input logic [2:0] mag);
        case (mag)
            3'd0:    mag_table = 32'h0000_0000;
            3'd1:    mag_table = 32'h0000_0001;
            3'd2:    mag_table = 32'h007F_FFFF;
            3'd3:    mag_table = 32'h7FA0_0000;
            3'd4:    mag_table = 32'h3F80_0000;
            3'd5:    mag_table = 32'h7F7F_FFFF;
            3'd6:    mag_table = 32'h7F80_0000;
            default: mag_table = 32'h7FC0_0000;
        endcase
    endfunction

    function automatic logic [31:0] operand(input logic [3:0] code);
        operand = mag_table(code[2:0]) | {code[3], 31'd0};
    endfunction

    function automatic logic [4:0] rm_onehot(input logic [2:0] idx);
        case (idx)
            3'd0:    rm_onehot = RM_RNE;
            3'd1:    rm_onehot = RM_RNA;
            3'd2:    rm_onehot = RM_RTP;
            3'd3:    rm_onehot = RM_RTN;
            default: rm_onehot = RM_RTZ;
        endcase
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_qnan(input logic [31:0] x);
        is_qnan = is_nan(x) && x[22];
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        is_snan = is_nan(x) && !x[22];
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        is_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

endpackage

// File: rtl/fp_edge_check.sv
// Combinational flag/result consistency checker for one FPU response.
// Operand c joins the NaN-propagation rule only when FP_EDGE_MULADD_EN is defined.
module fp_edge_check
    import fp_edge_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] o,
    input  logic [4:0]  flags,
    output logic        fail,
    output logic [5:0]  rule_fail
);

    logic [31:0] opnd [3];
    logic [2:0]  opnd_nan;
    logic        any_nan;

    assign opnd[0] = a;
    assign opnd[1] = b;
    assign opnd[2] = c;

    for (genvar gi = 0; gi < 3; gi++) begin : g_nan
        assign opnd_nan[gi] = is_nan(opnd[gi]);
    end

`ifdef FP_EDGE_MULADD_EN
    assign any_nan = |opnd_nan;
`else
    logic c_nan_unused;
    assign any_nan      = |opnd_nan[1:0];
    assign c_nan_unused = opnd_nan[2];
`endif

    always_comb begin
        rule_fail    = '0;
        rule_fail[0] = any_nan && (!is_nan(o) || (flags[FLAG_DZ:FLAG_NX] != 4'd0));
        rule_fail[1] = flags[FLAG_NV] && !is_qnan(o);
        rule_fail[2] = flags[FLAG_OF] && !flags[FLAG_NX];
        rule_fail[3] = flags[FLAG_UF] && !flags[FLAG_NX];
        rule_fail[4] = flags[FLAG_DZ] && !is_inf(o);
        rule_fail[5] = is_snan(a) && !flags[FLAG_NV];
    end

    assign fail = |rule_fail;

endmodule

// File: rtl/fp32_edge_stim.sv
// Walks the binary32 edge-operand table over all rounding modes, issues each vector to
// the FPU, and checks every response. FP_EDGE_MULADD_EN enables the c operand sweep.
module fp32_edge_stim
    import fp_edge_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [31:0]      req_a,
    output logic [31:0]      req_b,
    output logic [31:0]      req_c,
    output logic [4:0]       req_rm,
    input  logic             rsp_valid,
    input  logic [31:0]      rsp_o,
    input  logic [4:0]       rsp_flags,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] err_first
);

    state_t           state_reg, state_next;
    vec_idx_t         idx_reg, idx_next;
    logic             idx_last;
    logic             carry_rm, carry_b, carry_a;
    logic [31:0]      req_a_reg, req_b_reg, req_c_reg;
    logic [4:0]       req_rm_reg;
    logic [31:0]      rsp_o_reg;
    logic [4:0]       rsp_flags_reg;
    logic [CNT_W-1:0] err_count_reg, err_first_reg;
    logic             chk_fail;
    logic [5:0]       rule_fail_unused;

    // Index successor; the carry out of the top active field marks the last vector.
    always_comb begin
        idx_next        = idx_reg;
        carry_rm        = (idx_reg.rm_idx == RM_IDX_LAST);
        idx_next.rm_idx = carry_rm ? 3'd0 : idx_reg.rm_idx + 3'd1;
        carry_b         = carry_rm && (idx_reg.b_code == 4'hF);
        if (carry_rm)
            idx_next.b_code = idx_reg.b_code + 4'd1;
        carry_a = carry_b && (idx_reg.a_code == 4'hF);
        if (carry_b)
            idx_next.a_code = idx_reg.a_code + 4'd1;
`ifdef FP_EDGE_MULADD_EN
        if (carry_a)
            idx_next.c_code = idx_reg.c_code + 4'd1;
        idx_last = carry_a && (idx_reg.c_code == 4'hF);
`else
        idx_last = carry_a;
`endif
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_DONE);
        req_valid  = (state_reg == ST_ISSUE);
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_ISSUE;
            ST_ISSUE: if (req_ready) state_next = ST_WAIT;
            ST_WAIT:  if (rsp_valid) state_next = ST_CHECK;
            ST_CHECK: state_next = idx_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            req_a_reg     <= '0;
            req_b_reg     <= '0;
            req_c_reg     <= '0;
            req_rm_reg    <= RM_RNE;
            rsp_o_reg     <= '0;
            rsp_flags_reg <= '0;
            err_count_reg <= '0;
            err_first_reg <= '1;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        idx_reg       <= '0;
                        req_a_reg     <= operand(4'd0);
                        req_b_reg     <= operand(4'd0);
                        req_c_reg     <= operand(4'd0);
                        req_rm_reg    <= rm_onehot(3'd0);
                        err_count_reg <= '0;
                        err_first_reg <= '1;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        rsp_o_reg     <= rsp_o;
                        rsp_flags_reg <= rsp_flags;
                    end
                end
                ST_CHECK: begin
                    if (chk_fail) begin
                        if (err_count_reg != {CNT_W{1'b1}})
                            err_count_reg <= err_count_reg + CNT_W'(1);
                        if (err_first_reg == {CNT_W{1'b1}})
                            err_first_reg <= CNT_W'(idx_reg);
                    end
                    if (!idx_last) begin
                        idx_reg    <= idx_next;
                        req_a_reg  <= operand(idx_next.a_code);
                        req_b_reg  <= operand(idx_next.b_code);
                        req_c_reg  <= operand(idx_next.c_code);
                        req_rm_reg <= rm_onehot(idx_next.rm_idx);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_a  = req_a_reg;
    assign req_b  = req_b_reg;
    assign req_rm = req_rm_reg;
`ifdef FP_EDGE_MULADD_EN
    assign req_c  = req_c_reg;
`else
    logic [31:0] req_c_unused;
    assign req_c        = 32'h0000_0000;
    assign req_c_unused = req_c_reg;
`endif
    assign err_count = err_count_reg;
    assign err_first = err_first_reg;

    // Per-rule detail is left for waveform debug; only the summary bit is counted.
    fp_edge_check u_check (
        .a         (req_a),
        .b         (req_b),
        .c         (req_c),
        .o         (rsp_o_reg),
        .flags     (rsp_flags_reg),
        .fail      (chk_fail),
        .rule_fail (rule_fail_unused)
    );

endmodule
